pipe_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage pipeline.
- Sequences the enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Selects operand forwarding for the ID stage.
- Runs the request/acknowledge handshake with a multi-cycle data memory, with a timeout, plus a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: register enables/bubbles/flush,
// ID-stage forwarding selects and the data-memory request/ack handshake with timeout.
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [4:0]       drs,
   input  logic [4:0]       drt,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic [4:0]       ern,
   input  logic             ewreg,
   input  logic             em2reg,
   input  logic [4:0]       mrn,
   input  logic             mwreg,
   input  logic             mm2reg,
   input  logic             mm_acc,
   input  logic             e_taken,
   input  logic             dmem_ack,
   output logic             wpcir,
   output logic             fd_flush,
   output logic             de_bubble,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_bubble,
   output logic             dmem_req,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          lu, freeze, timed_out;

   // EX-stage ALU results win over anything still in MEM.
   function automatic logic [1:0] fwd_sel(input logic [4:0] x,
                                          input logic [4:0] e_rn, input logic e_w, input logic e_ld,
                                          input logic [4:0] m_rn, input logic m_w, input logic m_ld);
      if (e_w && !e_ld && e_rn != 5'd0 && e_rn == x)
         return 2'b01;
      else if (m_w && m_rn != 5'd0 && m_rn == x)
         return m_ld ? 2'b11 : 2'b10;
      else
         return 2'b00;
   endfunction

   assign fwda = fwd_sel(drs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
   assign fwdb = fwd_sel(drt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);

   assign lu = ewreg & em2reg & (ern != 5'd0) &
               (((ern == drs) & d_use_rs) | ((ern == drt) & d_use_rt));

   assign timed_out = (state == ST_WAIT) & ~dmem_ack & (timer == TW'(TIMEOUT));

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= ST_RUN;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // NOTE: every comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         ST_RUN: begin
            if (mm_acc && !dmem_ack) begin
               state_nxt = ST_WAIT;
               timer_nxt = TW'(1);
            end
         end
         ST_WAIT: begin
            if (dmem_ack || timed_out) begin
               state_nxt = ST_RUN;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
         end
      endcase
   end

   always_comb begin
      dmem_req  = 1'b0;
      freeze    = 1'b0;
      wpcir     = 1'b1;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      de_en     = 1'b1;
      em_en     = 1'b1;
      mw_bubble = 1'b0;
      case (state)
         ST_RUN: begin
            dmem_req = mm_acc;
            freeze   = mm_acc & ~dmem_ack;
         end
         ST_WAIT: begin
            dmem_req = 1'b1;
            freeze   = ~dmem_ack & ~timed_out;
         end
         default: ;
      endcase
      if (freeze) begin
         wpcir     = 1'b0;
         de_en     = 1'b0;
         em_en     = 1'b0;
         mw_bubble = 1'b1;
      end else if (e_taken) begin
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
      end else if (lu) begin
         wpcir     = 1'b0;
         de_bubble = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (timed_out)
            mem_err <= 1'b1;
         if (!wpcir && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, flush, memory
// handshake, timeout, counter saturation and asynchronous reset mid-access.
module tb_pipe_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic             clock = 1'b0;
   logic             resetn;
   logic [4:0]       drs, drt, ern, mrn;
   logic             d_use_rs, d_use_rt, ewreg, em2reg, mwreg, mm2reg, mm_acc, e_taken, dmem_ack;
   logic             wpcir, fd_flush, de_bubble, de_en, em_en, mw_bubble, dmem_req, mem_err;
   logic [1:0]       fwda, fwdb;
   logic [CNT_W-1:0] stall_cycles;

   int passed = 0;
   int total  = 0;

   pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock(clock), .resetn(resetn),
      .drs(drs), .drt(drt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .mm_acc(mm_acc),
      .e_taken(e_taken), .dmem_ack(dmem_ack),
      .wpcir(wpcir), .fd_flush(fd_flush), .de_bubble(de_bubble), .de_en(de_en),
      .em_en(em_en), .mw_bubble(mw_bubble), .dmem_req(dmem_req),
      .fwda(fwda), .fwdb(fwdb), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge; inputs are then driven and
   // outputs sampled a couple of time units later, well away from the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      drs = 5'd0; drt = 5'd0; ern = 5'd0; mrn = 5'd0;
      d_use_rs = 1'b0; d_use_rt = 1'b0; ewreg = 1'b0; em2reg = 1'b0;
      mwreg = 1'b0; mm2reg = 1'b0; mm_acc = 1'b0; e_taken = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic reset_pulse();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      #1;
   endtask

   initial begin
      clear_inputs();
      resetn = 1'b0;
      #12 resetn = 1'b1;
      tick();

      // Idle after reset
      #2;
      check("idle_wpcir", wpcir, 1);
      check("idle_de_en", de_en, 1);
      check("idle_em_en", em_en, 1);
      check("idle_mw_bubble", mw_bubble, 0);
      check("idle_fwda", fwda, 0);
      check("idle_fwdb", fwdb, 0);
      check("idle_stall", stall_cycles, 0);
      check("idle_dmem_req", dmem_req, 0);
      check("idle_mem_err", mem_err, 0);

      // Forwarding
      ewreg = 1; em2reg = 0; ern = 5'd3; drs = 5'd3; mwreg = 1; mrn = 5'd3; mm2reg = 0;
      #1;
      check("fwd_ex_prio", fwda, 2'b01);
      check("fwd_rt_none", fwdb, 2'b00);
      ewreg = 0; mm2reg = 1;
      #1;
      check("fwd_mem_load", fwda, 2'b11);
      mm2reg = 0; drt = 5'd3;
      #1;
      check("fwd_mem_alu", fwda, 2'b10);
      check("fwdb_mem_alu", fwdb, 2'b10);
      ewreg = 1; ern = 5'd7; drt = 5'd7;
      #1;
      check("fwdb_ex", fwdb, 2'b01);
      ern = 5'd0; drs = 5'd0; drt = 5'd0; mrn = 5'd0;
      #1;
      check("fwd_r0_a", fwda, 2'b00);
      check("fwd_r0_b", fwdb, 2'b00);
      check("fwd_no_stall", wpcir, 1);
      tick();
      clear_inputs();

      // Load-use hazard for one cycle
      ewreg = 1; em2reg = 1; ern = 5'd5; drt = 5'd5; d_use_rt = 1;
      #2;
      check("lu_wpcir", wpcir, 0);
      check("lu_de_bubble", de_bubble, 1);
      check("lu_de_en", de_en, 1);
      check("lu_fd_flush", fd_flush, 0);
      tick();
      ewreg = 0; em2reg = 0;
      #2;
      check("lu_stall_cnt", stall_cycles, 1);
      check("lu_gone_wpcir", wpcir, 1);
      check("lu_gone_bubble", de_bubble, 0);
      ewreg = 1; em2reg = 1; d_use_rt = 0;
      #1;
      check("lu_unused_rt", wpcir, 1);
      // Flush has priority over load-use
      d_use_rt = 1; e_taken = 1;
      #1;
      check("flush_fd_flush", fd_flush, 1);
      check("flush_wpcir", wpcir, 1);
      check("flush_de_bubble", de_bubble, 1);
      tick();
      clear_inputs();
      #2;
      check("flush_no_stall", stall_cycles, 1);

      // Multi-cycle memory access, ack on the 4th request cycle
      reset_pulse();
      tick();
      mm_acc = 1;
      for (int c = 1; c <= 3; c++) begin
         #2;
         check($sformatf("mem_req_c%0d", c), dmem_req, 1);
         check($sformatf("mem_wpcir_c%0d", c), wpcir, 0);
         check($sformatf("mem_mwb_c%0d", c), mw_bubble, 1);
         check($sformatf("mem_em_en_c%0d", c), em_en, 0);
         tick();
      end
      dmem_ack = 1;
      #2;
      check("mem_ack_req", dmem_req, 1);
      check("mem_ack_wpcir", wpcir, 1);
      check("mem_ack_mwb", mw_bubble, 0);
      tick();
      mm_acc = 0; dmem_ack = 0;
      #2;
      check("mem_back_run", dmem_req, 0);
      check("mem_stall_cnt", stall_cycles, 3);

      // Zero-wait access
      mm_acc = 1; dmem_ack = 1;
      #1;
      check("zw_req", dmem_req, 1);
      check("zw_wpcir", wpcir, 1);
      check("zw_mwb", mw_bubble, 0);
      tick();
      mm_acc = 0;
      #2;
      // Stray ack with no request is ignored
      check("stray_req", dmem_req, 0);
      check("stray_wpcir", wpcir, 1);
      tick();
      dmem_ack = 0;
      #2;
      check("zw_stall_cnt", stall_cycles, 3);

      // Timeout: 4 frozen cycles, released on the 5th request cycle
      mm_acc = 1;
      for (int c = 1; c <= 4; c++) begin
         #2;
         check($sformatf("to_wpcir_c%0d", c), wpcir, 0);
         check($sformatf("to_err_c%0d", c), mem_err, 0);
         tick();
      end
      #2;
      check("to_req_c5", dmem_req, 1);
      check("to_release_c5", wpcir, 1);
      check("to_mwb_c5", mw_bubble, 0);
      tick();
      mm_acc = 0;
      #2;
      check("to_mem_err", mem_err, 1);
      check("to_back_run", dmem_req, 0);
      check("to_stall_cnt", stall_cycles, 7);
      tick();
      tick();
      check("to_err_sticky", mem_err, 1);

      // Saturation of the stall counter (CNT_W=4 -> 15)
      ewreg = 1; em2reg = 1; ern = 5'd9; drs = 5'd9; d_use_rs = 1;
      for (int c = 0; c < 8; c++) tick();
      check("sat_reach", stall_cycles, 15);
      tick();
      tick();
      check("sat_hold", stall_cycles, 15);
      clear_inputs();

      // Asynchronous reset in the middle of a WAIT
      mm_acc = 1;
      tick();
      tick();
      mm_acc = 0;
      #2;
      check("rst_pre_wait_req", dmem_req, 1);
      resetn = 0;
      #1;
      check("rst_req_drop", dmem_req, 0);
      check("rst_wpcir", wpcir, 1);
      check("rst_mem_err", mem_err, 0);
      check("rst_stall", stall_cycles, 0);
      #2 resetn = 1;
      tick();
      #2;
      check("rst_after_req", dmem_req, 0);
      check("rst_after_err", mem_err, 0);
      check("rst_after_stall", stall_cycles, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
